mii_tx_scheduler: RTL and testbench
===================================

# mii_tx_scheduler

Frame scheduler that shares the single 64-bit 1.6T MII transmit lane between N_REQ payload sources. Each source streams data words with valid/ready/last; the block grants one source per frame, round-robin, and wraps its payload in START/EOF control words, enforcing a minimum IDLE gap between frames. It aborts frames on underrun or overlength with an ERROR control word. It drives the TX MII word stream consumed by the MII generator checker and the downstream PCS.

## Interface
- DATA_WIDTH, 64, MII word width; fixed at 64 (8 lanes × 8 bits)
- N_REQ, 2, number of payload sources, 2..4
- IPG_WORDS, 1, minimum IDLE words between an EOF/ERROR word and the next START, ≥1
- MAX_WORDS, 256, maximum data words per frame
- clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_enable  in  1  allows new grants; sampled only when idle and arbitrating
- i_req_valid  in  N_REQ  per-source word valid
- i_req_data  in  N_REQ×64  per-source payload; source k at bits [64k+63:64k]
- i_req_last  in  N_REQ  marks final word of a frame
- o_req_ready  out  N_REQ  word accept strobe; at most one bit high
- o_tx_data  out  64  MII word
- o_tx_ctrl  out  1  1 = control word, 0 = data word
- o_grant_id  out  $clog2(N_REQ)  source owning the current/last frame
- o_busy  out  1  high from START output until the gap ends
- o_abort  out  1  one-cycle pulse coincident with an ERROR word on o_tx_data

## Operation
- Words: IDLE = eight 8'h07, ctrl 1. START = seven 8'h07 in bytes 7..1, 8'hFB in byte 0, ctrl 1. EOF = 8'hFD in byte 7, seven 8'h07 below, ctrl 1. ERROR = eight 8'hFE, ctrl 1. Data: ctrl 0, payload verbatim.
- States: S_IDLE, S_DATA, S_EOF, S_DRAIN, S_IPG.
- S_IDLE: emit IDLE. If i_enable and any i_req_valid, the round-robin grant picks the first valid source after the last granted one. START goes out next; go to S_DATA.
- S_DATA: o_req_ready[grant]=1 (combinational from state and grant). On valid, emit the word (ctrl 0) and increment the word counter. On last, go to S_EOF. If the MAX_WORDS-th word is not last, emit ERROR next and go to S_DRAIN. If valid is low while ready (underrun), emit ERROR and go to S_DRAIN.
- S_EOF: emit EOF, ready 0, go to S_IPG.
- S_DRAIN: ready stays high to the granted source. Accepted words are discarded and IDLE is emitted until valid&&last is accepted; then go to S_IPG.
- S_IPG: emit IDLE. The gap counter enforces exactly IPG_WORDS IDLE words after EOF/ERROR before a START can appear; then go to S_IDLE.
- Round-robin pointer: updates only on grant. Reset value N_REQ-1, so source 0 wins first.
- i_enable low mid-frame does not abort; it only blocks the next grant.
- Word counter: $clog2(MAX_WORDS+1) bits, cleared on grant.

## Timing
- All outputs except o_req_ready are registered.
- Reset (async): o_tx_data=IDLE, o_tx_ctrl=1, o_req_ready=0, o_grant_id=0, o_busy=0, o_abort=0. State is S_IDLE, pointer is N_REQ-1, counters are 0.
- Latency: valid at cycle t in S_IDLE → START on o_tx at t+1, ready high at t+1, first data word on o_tx at t+2. A word accepted at cycle c appears at c+1.
- For a continuously valid source with an n-word frame, the stream is START, D0..Dn-1, EOF, IPG_WORDS×IDLE, START…
- The first cycle after the gap is S_IDLE and can grant; no extra IDLE beyond IPG_WORDS when a request is pending.
- Simultaneous valid from all sources: grant strictly rotates, one frame per source.
- Reset mid-frame: outputs return to IDLE immediately and no EOF is sent; sources must reset their own frame state.

## Structure
- Package mii_pkg: IDLE_CODE 8'h07, START_CODE 8'hFB, EOF_CODE 8'hFD, ERROR_CODE 8'hFE, the 64-bit IDLE/START/EOF/ERROR word constants, and the state_t enum.
- Sub-module rr_arbiter: parameter N_REQ; inputs req vector and accept; outputs one-hot grant and index; owns the rotating pointer.

## Test plan
- Source 0 sends a 3-word frame AA..AA, BB..BB, CC..CC, IPG_WORDS=1 → IDLE, START, AA(ctrl0), BB, CC, EOF, IDLE; o_grant_id=0.
- Both sources continuously valid, 2-word frames → grants alternate 0,1,0,1; exactly one IDLE between each EOF and START.
- Source drops valid after 1 of 4 words → ERROR word with o_abort=1; remaining words drained with ready high; IDLE out; no EOF.
- 257-word frame, MAX_WORDS=256 → 256 data words, then ERROR; word 257 (last) drained; next START after IPG_WORDS IDLEs.
- i_enable low with valid pending → IDLE held, ready 0. i_enable high at cycle t → START at t+1. i_enable dropped mid-frame → frame completes with EOF.
- i_rst pulsed mid-DATA → o_tx_data=IDLE, ctrl 1, ready 0 within the reset cycle. After release, source 0 has priority.

Source files
------------

// File: rtl/mii_tx_scheduler_pkg.sv
// Shared constants, MII control words and FSM state type
// for the 1.6T MII transmit scheduler.
package mii_pkg;

    localparam int MII_WIDTH = 64;

    localparam logic [7:0] IDLE_CODE  = 8'h07;
    localparam logic [7:0] START_CODE = 8'hFB;
    localparam logic [7:0] EOF_CODE   = 8'hFD;
    localparam logic [7:0] ERROR_CODE = 8'hFE;

    localparam logic [63:0] IDLE_WORD  = {8{IDLE_CODE}};
    localparam logic [63:0] START_WORD = {{7{IDLE_CODE}}, START_CODE};
    localparam logic [63:0] EOF_WORD   = {EOF_CODE, {7{IDLE_CODE}}};
    localparam logic [63:0] ERROR_WORD = {8{ERROR_CODE}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_EOF,
        S_DRAIN,
        S_IPG
    } state_t;

    function automatic int idx_width(int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mii_tx_scheduler_if.sv
// Payload-source and TX MII bundle between the sources,
// the scheduler and the downstream consumer.
interface mii_tx_scheduler_if
    import mii_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int DATA_WIDTH = 64
);
    localparam int GW = idx_width(N_REQ);

    logic [N_REQ-1:0]            i_req_valid;
    logic [N_REQ*DATA_WIDTH-1:0] i_req_data;
    logic [N_REQ-1:0]            i_req_last;
    logic [N_REQ-1:0]            o_req_ready;
    logic [DATA_WIDTH-1:0]       o_tx_data;
    logic                        o_tx_ctrl;
    logic [GW-1:0]               o_grant_id;
    logic                        o_busy;
    logic                        o_abort;

    modport master (
        output i_req_valid, i_req_data, i_req_last,
        input  o_req_ready, o_tx_data, o_tx_ctrl,
        input  o_grant_id, o_busy, o_abort
    );

    modport slave (
        input  i_req_valid, i_req_data, i_req_last,
        output o_req_ready, o_tx_data, o_tx_ctrl,
        output o_grant_id, o_busy, o_abort
    );

endinterface

// File: rtl/mii_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requester after the last grant wins;
// the pointer only moves when a grant is accepted.
module rr_arbiter
    import mii_pkg::*;
#(
    parameter int N_REQ = 2,
    localparam int IW   = idx_width(N_REQ)
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_accept,
    output logic [N_REQ-1:0] o_grant,
    output logic [IW-1:0]    o_index
);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_cand;
    logic          w_found;

    always_comb begin
        w_found = 1'b0;
        w_cand  = '0;
        o_index = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_cand = IW'((int'(r_ptr) + i) % N_REQ);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                o_index = w_cand;
            end
        end
        o_grant = '0;
        if (w_found) o_grant[o_index] = 1'b1;
    end

    // Reset to the last index so source 0 wins the first grant
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= IW'(N_REQ - 1);
        end else if (i_accept && w_found) begin
            r_ptr <= o_index;
        end
    end

endmodule

// File: rtl/mii_tx_scheduler.sv
// Frames N_REQ payload streams onto one 64-bit TX MII lane with
// START/EOF framing, IDLE gap enforcement and ERROR aborts.
module mii_tx_scheduler
    import mii_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int N_REQ      = 2,
    parameter int IPG_WORDS  = 1,
    parameter int MAX_WORDS  = 256
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_enable,
    mii_tx_scheduler_if.slave io_mii
);

    localparam int GW = idx_width(N_REQ);
    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam int PW = idx_width(IPG_WORDS);

    state_t                r_state, w_state_n;
    logic [CW-1:0]         r_cnt, w_cnt_n;
    logic [PW-1:0]         r_gap, w_gap_n;
    logic                  r_err_pend, w_err_n;
    logic [DATA_WIDTH-1:0] r_tx_data, w_data_n;
    logic                  r_tx_ctrl, w_ctrl_n;
    logic [GW-1:0]         r_gid, w_gid_n;
    logic                  r_busy, w_busy_n;
    logic                  r_abort, w_abort_n;

    logic [N_REQ-1:0]      w_grant_oh;
    logic [GW-1:0]         w_grant_idx;
    logic                  w_accept;
    logic [N_REQ-1:0]      w_ready;
    logic [DATA_WIDTH-1:0] w_src_data [N_REQ];
    logic                  w_sel_valid;
    logic                  w_sel_last;
    logic [DATA_WIDTH-1:0] w_sel_data;

    for (genvar g = 0; g < N_REQ; g++) begin : g_src
        assign w_src_data[g] =
            io_mii.i_req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_sel_valid = io_mii.i_req_valid[r_gid];
    assign w_sel_last  = io_mii.i_req_last[r_gid];
    assign w_sel_data  = w_src_data[r_gid];
    assign w_accept    = (r_state == S_IDLE) && i_enable;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk      (clk),
        .i_rst    (i_rst),
        .i_req    (io_mii.i_req_valid),
        .i_accept (w_accept),
        .o_grant  (w_grant_oh),
        .o_index  (w_grant_idx)
    );

    always_comb begin
        w_ready = '0;
        if (r_state == S_DATA || r_state == S_DRAIN)
            w_ready[r_gid] = 1'b1;
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_gap_n   = r_gap;
        w_err_n   = 1'b0;
        w_data_n  = IDLE_WORD;
        w_ctrl_n  = 1'b1;
        w_gid_n   = r_gid;
        w_abort_n = 1'b0;
        w_busy_n  = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (i_enable && (|w_grant_oh)) begin
                    w_state_n = S_DATA;
                    w_data_n  = START_WORD;
                    w_gid_n   = w_grant_idx;
                    w_cnt_n   = '0;
                    w_busy_n  = 1'b1;
                end
            end
            S_DATA: begin
                if (w_sel_valid) begin
                    w_data_n = w_sel_data;
                    w_ctrl_n = 1'b0;
                    w_cnt_n  = r_cnt + 1'b1;
                    if (w_sel_last) begin
                        w_state_n = S_EOF;
                    end else if (r_cnt == CW'(MAX_WORDS - 1)) begin
                        w_state_n = S_DRAIN;
                        w_err_n   = 1'b1;
                    end
                end else begin
                    w_data_n  = ERROR_WORD;
                    w_abort_n = 1'b1;
                    w_state_n = S_DRAIN;
                end
            end
            S_EOF: begin
                w_data_n  = EOF_WORD;
                w_state_n = S_IPG;
            end
            S_DRAIN: begin
                // Overlength ERROR follows the last kept data word
                if (r_err_pend) begin
                    w_data_n  = ERROR_WORD;
                    w_abort_n = 1'b1;
                end
                if (w_sel_valid && w_sel_last)
                    w_state_n = S_IPG;
            end
            S_IPG: begin
                if (r_gap == PW'(IPG_WORDS - 1)) begin
                    w_state_n = S_IDLE;
                    w_gap_n   = '0;
                end else begin
                    w_gap_n = r_gap + 1'b1;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_gap      <= '0;
            r_err_pend <= 1'b0;
            r_tx_data  <= IDLE_WORD;
            r_tx_ctrl  <= 1'b1;
            r_gid      <= '0;
            r_busy     <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_gap      <= w_gap_n;
            r_err_pend <= w_err_n;
            r_tx_data  <= w_data_n;
            r_tx_ctrl  <= w_ctrl_n;
            r_gid      <= w_gid_n;
            r_busy     <= w_busy_n;
            r_abort    <= w_abort_n;
        end
    end

    assign io_mii.o_req_ready = w_ready;
    assign io_mii.o_tx_data   = r_tx_data;
    assign io_mii.o_tx_ctrl   = r_tx_ctrl;
    assign io_mii.o_grant_id  = r_gid;
    assign io_mii.o_busy      = r_busy;
    assign io_mii.o_abort     = r_abort;

endmodule

// File: tb/tb_mii_tx_scheduler.sv
// Self-checking bench for mii_tx_scheduler: vector table, directed
// corner sequences and random frames against a frame-level model.
module tb_mii_tx_scheduler;
    import mii_pkg::*;

    localparam int N    = 2;
    localparam int IPG  = 1;
    localparam int MAXW = 256;
    localparam int DW   = 64;

    logic clk = 1'b0;
    logic rst;
    logic en;

    mii_tx_scheduler_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();

    mii_tx_scheduler #(
        .DATA_WIDTH (DW),
        .N_REQ      (N),
        .IPG_WORDS  (IPG),
        .MAX_WORDS  (MAXW)
    ) dut (
        .clk      (clk),
        .i_rst    (rst),
        .i_enable (en),
        .io_mii   (bus)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    typedef struct {
        logic        en;
        logic [1:0]  v;
        logic [1:0]  l;
        logic [63:0] d0;
        logic [63:0] d1;
        logic        c;
        logic [63:0] x;
        logic [1:0]  r;
        logic        b;
        logic        a;
        logic        g;
    } vec_t;

    typedef struct packed {
        logic        c;
        logic [63:0] d;
        logic        a;
        logic        b;
        logic [1:0]  r;
        logic        g;
    } ow_t;

    vec_t        tv [14];
    logic [64:0] sq [N][$];
    logic [N-1:0] gate;
    ow_t         obs [$];
    ow_t         expq [$];
    int          m_ptr;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setv(int i, logic e, logic [1:0] v, logic [1:0] l,
                        logic [63:0] d0, logic [63:0] d1, logic c,
                        logic [63:0] x, logic [1:0] r, logic b,
                        logic a, logic g);
        tv[i].en = e; tv[i].v = v; tv[i].l = l;
        tv[i].d0 = d0; tv[i].d1 = d1; tv[i].c = c;
        tv[i].x = x; tv[i].r = r; tv[i].b = b;
        tv[i].a = a; tv[i].g = g;
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (sq[k].size() > 0) begin
                bus.i_req_valid[k] = gate[k];
                bus.i_req_data[k*DW +: DW] = sq[k][0][63:0];
                bus.i_req_last[k] = sq[k][0][64];
            end else begin
                bus.i_req_valid[k] = 1'b0;
                bus.i_req_data[k*DW +: DW] = '0;
                bus.i_req_last[k] = 1'b0;
            end
        end
    endtask

    task automatic step();
        logic [N-1:0] acc;
        ow_t o;
        @(negedge clk);
        acc = bus.i_req_valid & bus.o_req_ready;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++)
            if (acc[k]) void'(sq[k].pop_front());
        drive();
        o.c = bus.o_tx_ctrl;
        o.d = bus.o_tx_data;
        o.a = bus.o_abort;
        o.b = bus.o_busy;
        o.r = bus.o_req_ready;
        o.g = bus.o_grant_id;
        obs.push_back(o);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < N; k++) sq[k].delete();
        gate = '1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_ptr = N - 1;
        obs.delete();
    endtask

    task automatic pushw(logic c, logic [63:0] d, logic a, logic b,
                         logic g);
        ow_t e;
        e.c = c; e.d = d; e.a = a; e.b = b; e.r = '0; e.g = g;
        expq.push_back(e);
    endtask

    // Frame-level reference: round-robin over pending frames, each
    // framed START/data/EOF (or cut at MAXW with ERROR), then the gap
    task automatic build_exp();
        logic [64:0] cq [N][$];
        int pick;
        int n;
        logic [64:0] w;
        expq.delete();
        for (int k = 0; k < N; k++) cq[k] = sq[k];
        forever begin
            pick = -1;
            for (int i = 1; i <= N; i++)
                if (pick < 0 && cq[(m_ptr + i) % N].size() > 0)
                    pick = (m_ptr + i) % N;
            if (pick < 0) break;
            m_ptr = pick;
            pushw(1'b1, START_WORD, 1'b0, 1'b1, pick[0]);
            n = 0;
            do begin
                w = cq[pick].pop_front();
                n++;
                if (n <= MAXW) pushw(1'b0, w[63:0], 1'b0, 1'b1, pick[0]);
            end while (!w[64]);
            if (n <= MAXW) begin
                pushw(1'b1, EOF_WORD, 1'b0, 1'b1, pick[0]);
                repeat (IPG) pushw(1'b1, IDLE_WORD, 1'b0, 1'b1, pick[0]);
            end else begin
                pushw(1'b1, ERROR_WORD, 1'b1, 1'b1, pick[0]);
                repeat (n - MAXW - 1 + IPG)
                    pushw(1'b1, IDLE_WORD, 1'b0, 1'b1, pick[0]);
            end
        end
    endtask

    task automatic run(string name, int budget);
        int n;
        bit pend;
        n = 0;
        pend = 1'b1;
        while (pend && n < budget) begin
            step();
            n++;
            pend = 1'b0;
            for (int k = 0; k < N; k++)
                if (sq[k].size() > 0) pend = 1'b1;
        end
        if (pend) begin
            checks++;
            errs++;
            $display("FAIL %s_timeout: sources not drained in %0d cycles",
                     name, budget);
        end
        repeat (IPG + 6) step();
    endtask

    task automatic compare(string name);
        int s;
        s = -1;
        for (int i = 0; i < obs.size(); i++)
            if (s < 0 && !(obs[i].c && obs[i].d == IDLE_WORD)) s = i;
        if (s < 0) begin
            checks++;
            errs++;
            $display("FAIL %s_start: got none expected START", name);
            return;
        end
        for (int i = 0; i < expq.size(); i++) begin
            if (s + i >= obs.size()) begin
                checks++;
                errs++;
                $display("FAIL %s_len: got %0d words expected %0d",
                         name, obs.size() - s, expq.size());
                return;
            end
            chk($sformatf("%s_data[%0d]", name, i),
                obs[s+i].d, expq[i].d);
            chk($sformatf("%s_cab[%0d]", name, i),
                {61'd0, obs[s+i].c, obs[s+i].a, obs[s+i].b},
                {61'd0, expq[i].c, expq[i].a, expq[i].b});
            if (expq[i].c && expq[i].d == START_WORD)
                chk($sformatf("%s_gid[%0d]", name, i),
                    {63'd0, obs[s+i].g}, {63'd0, expq[i].g});
        end
        if (s + expq.size() < obs.size())
            chk($sformatf("%s_tail", name),
                {obs[s+expq.size()].d[62:0], obs[s+expq.size()].b},
                {IDLE_WORD[62:0], 1'b0});
    endtask

    task automatic load(int k, int len, logic [63:0] base);
        for (int i = 0; i < len; i++)
            sq[k].push_back({(i == len - 1), base + 64'(i)});
    endtask

    localparam logic [63:0] AA = {8{8'hAA}};
    localparam logic [63:0] BB = {8{8'hBB}};
    localparam logic [63:0] CC = {8{8'hCC}};
    localparam logic [63:0] D1 = {8{8'h11}};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int eofs;
        int cnt;
        int tot;
        rst = 1'b1;
        en  = 1'b0;
        bus.i_req_valid = '0;
        bus.i_req_data  = '0;
        bus.i_req_last  = '0;
        gate = '1;
        #1;
        chk("rst_data", bus.o_tx_data, IDLE_WORD);
        chk("rst_ctrl", {63'd0, bus.o_tx_ctrl}, 64'd1);
        chk("rst_ready", {62'd0, bus.o_req_ready}, 64'd0);
        chk("rst_gid", {63'd0, bus.o_grant_id}, 64'd0);
        chk("rst_busy", {63'd0, bus.o_busy}, 64'd0);
        chk("rst_abort", {63'd0, bus.o_abort}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // en, valid, last, d0, d1 -> ctrl, data, ready, busy, abort, gid
        setv(0, 0, 2'b01, 2'b00, AA, 0, 1, IDLE_WORD, 2'b00, 0, 0, 0);
        setv(1, 0, 2'b01, 2'b00, AA, 0, 1, IDLE_WORD, 2'b00, 0, 0, 0);
        setv(2, 1, 2'b01, 2'b00, AA, 0, 1, START_WORD, 2'b01, 1, 0, 0);
        setv(3, 1, 2'b01, 2'b00, AA, 0, 0, AA, 2'b01, 1, 0, 0);
        setv(4, 0, 2'b01, 2'b00, BB, 0, 0, BB, 2'b01, 1, 0, 0);
        setv(5, 0, 2'b01, 2'b01, CC, 0, 0, CC, 2'b00, 1, 0, 0);
        setv(6, 0, 2'b00, 2'b00, 0, 0, 1, EOF_WORD, 2'b00, 1, 0, 0);
        setv(7, 0, 2'b00, 2'b00, 0, 0, 1, IDLE_WORD, 2'b00, 1, 0, 0);
        setv(8, 0, 2'b00, 2'b00, 0, 0, 1, IDLE_WORD, 2'b00, 0, 0, 0);
        setv(9, 1, 2'b10, 2'b10, 0, D1, 1, START_WORD, 2'b10, 1, 0, 1);
        setv(10, 1, 2'b10, 2'b10, 0, D1, 0, D1, 2'b00, 1, 0, 1);
        setv(11, 1, 2'b00, 2'b00, 0, 0, 1, EOF_WORD, 2'b00, 1, 0, 1);
        setv(12, 1, 2'b00, 2'b00, 0, 0, 1, IDLE_WORD, 2'b00, 1, 0, 1);
        setv(13, 1, 2'b00, 2'b00, 0, 0, 1, IDLE_WORD, 2'b00, 0, 0, 1);
        for (int i = 0; i < 14; i++) begin
            en = tv[i].en;
            bus.i_req_valid = tv[i].v;
            bus.i_req_last  = tv[i].l;
            bus.i_req_data  = {tv[i].d1, tv[i].d0};
            @(posedge clk);
            #1;
            chk($sformatf("tab_data[%0d]", i), bus.o_tx_data, tv[i].x);
            chk($sformatf("tab_flags[%0d]", i),
                {58'd0, bus.o_tx_ctrl, bus.o_req_ready, bus.o_busy,
                 bus.o_abort, bus.o_grant_id},
                {58'd0, tv[i].c, tv[i].r, tv[i].b, tv[i].a, tv[i].g});
        end

        en = 1'b1;
        do_reset();
        load(0, 2, 64'h1000); load(0, 2, 64'h1100);
        load(1, 2, 64'h2000); load(1, 2, 64'h2100);
        drive();
        build_exp();
        run("alt", 100);
        compare("alt");

        do_reset();
        load(0, 4, 64'h3000);
        drive();
        step();
        step();
        gate[0] = 1'b0;
        drive();
        step();
        gate[0] = 1'b1;
        drive();
        repeat (8) step();
        chk("ur_start", obs[0].d, START_WORD);
        chk("ur_d0", {obs[1].d[62:0], obs[1].c}, {63'h3000, 1'b0});
        chk("ur_err", obs[2].d, ERROR_WORD);
        chk("ur_err_flags", {61'd0, obs[2].c, obs[2].a, obs[2].r[0]},
            {61'd0, 3'b111});
        eofs = 0;
        for (int i = 3; i < obs.size(); i++)
            if (obs[i].c && (obs[i].d == EOF_WORD || obs[i].a)) eofs++;
        chk("ur_no_eof", 64'(eofs), 64'd0);
        chk("ur_drained", 64'(sq[0].size()), 64'd0);
        chk("ur_end_busy", {63'd0, obs[obs.size()-1].b}, 64'd0);

        do_reset();
        load(0, MAXW, 64'h4000);
        load(0, 2, 64'h4400);
        load(1, MAXW + 1, 64'h5000);
        drive();
        build_exp();
        run("ovl", 2000);
        compare("ovl");

        do_reset();
        load(0, 5, 64'h6000);
        drive();
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_data", bus.o_tx_data, IDLE_WORD);
        chk("mrst_flags",
            {59'd0, bus.o_tx_ctrl, bus.o_req_ready, bus.o_busy,
             bus.o_abort},
            {59'd0, 1'b1, 2'b00, 1'b0, 1'b0});
        for (int k = 0; k < N; k++) sq[k].delete();
        load(1, 1, 64'h7100);
        load(0, 1, 64'h7000);
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ptr = N - 1;
        obs.delete();
        build_exp();
        run("mrst", 100);
        compare("mrst");

        for (int r = 0; r < 6; r++) begin
            tot = 0;
            for (int k = 0; k < N; k++) begin
                cnt = $urandom_range(0, 3);
                for (int f = 0; f < cnt; f++)
                    load(k, $urandom_range(1, 6), {$urandom(), $urandom()});
                tot += cnt;
            end
            if (tot == 0) load(r % N, 3, {$urandom(), $urandom()});
            drive();
            obs.delete();
            build_exp();
            run($sformatf("rnd%0d", r), 400);
            compare($sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
